// File: rtl/bus_slave_regfile.sv
// Bus slave responder backed by a small word register file.
// An access starts with cs_ and as_ both low at a clock edge. The slave then inserts
// WAIT_CYCLES wait states and answers with a single-cycle, active-low rdy_ pulse.
// rd_data and rdy_ are registered, and they show an idle slave outside the answer cycle.
module bus_slave_regfile #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 30,
    parameter int REG_NUM     = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs_,
    input  logic              as_,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rdy_
);

    localparam int          IDX_W     = $clog2(REG_NUM);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_next_s;
    logic [3:0]          cnt_r;
    logic [3:0]          cnt_next_s;
    logic                start_s;

    // Access attributes latched when the strobe is accepted.
    logic                rw_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   wr_data_r;

    // Attributes of the access in flight. With zero wait states the write commits
    // on the strobe edge itself, so the live bus inputs must be used there.
    logic                acc_rw_s;
    logic [ADDR_W-1:0]   acc_addr_s;
    logic [DATA_W-1:0]   acc_wr_data_s;
    logic                wr_en_s;

    logic [DATA_W-1:0]   regs_r [REG_NUM];
    logic [DATA_W-1:0]   rd_data_r;
    logic                rdy_r;

    // An address maps onto a register only when every bit above the index is clear.
    // Otherwise a read returns zero and a write is dropped.
    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return (a >> IDX_W) == {ADDR_W{1'b0}};
    endfunction

    // Next-state and wait-counter logic of the IDLE/WAIT/ACK handshake.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        start_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!cs_ && !as_) begin
                    start_s = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_next_s = ST_ACK;
                        cnt_next_s   = 4'd0;
                    end else begin
                        state_next_s = ST_WAIT;
                        cnt_next_s   = WAIT_INIT;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cs_) begin
                    // The master gave up, so drop the access without a write or a rdy_.
                    state_next_s = ST_IDLE;
                    cnt_next_s   = 4'd0;
                end else if (cnt_r <= 4'd1) begin
                    state_next_s = ST_ACK;
                    cnt_next_s   = 4'd0;
                end else begin
                    cnt_next_s   = cnt_r - 4'd1;
                end
            end
            ST_ACK: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = 4'd0;
            end
            default: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = 4'd0;
            end
        endcase
    end

    // Choose the live inputs or the latched copy of the current access, and decide
    // whether the write commits on the edge that enters ACK.
    always_comb begin
        acc_rw_s      = rw_r;
        acc_addr_s    = addr_r;
        acc_wr_data_s = wr_data_r;
        if (start_s) begin
            acc_rw_s      = rw;
            acc_addr_s    = addr;
            acc_wr_data_s = wr_data;
        end else begin
            acc_rw_s      = rw_r;
            acc_addr_s    = addr_r;
            acc_wr_data_s = wr_data_r;
        end
        wr_en_s = (state_next_s == ST_ACK) && !acc_rw_s && in_range(acc_addr_s);
    end

    // State register, wait counter and latch for the accepted access.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 4'd0;
            rw_r      <= 1'b0;
            addr_r    <= {ADDR_W{1'b0}};
            wr_data_r <= {DATA_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            if (start_s) begin
                rw_r      <= rw;
                addr_r    <= addr;
                wr_data_r <= wr_data;
            end else begin
                rw_r      <= rw_r;
                addr_r    <= addr_r;
                wr_data_r <= wr_data_r;
            end
        end
    end

    // Backing register file. A write commits as the access enters ACK.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else if (wr_en_s) begin
            regs_r[acc_addr_s[IDX_W-1:0]] <= acc_wr_data_s;
        end else begin
            regs_r <= regs_r;
        end
    end

    // Registered bus response: rdy_ pulses low for one cycle after ACK, and
    // read data is driven only in that cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdy_r     <= 1'b1;
            rd_data_r <= {DATA_W{1'b0}};
        end else if (state_r == ST_ACK) begin
            rdy_r <= 1'b0;
            if (rw_r && in_range(addr_r)) begin
                rd_data_r <= regs_r[addr_r[IDX_W-1:0]];
            end else begin
                rd_data_r <= {DATA_W{1'b0}};
            end
        end else begin
            rdy_r     <= 1'b1;
            rd_data_r <= {DATA_W{1'b0}};
        end
    end

    assign rdy_    = rdy_r;
    assign rd_data = rd_data_r;

endmodule

// File: tb/tb_bus_slave_regfile.sv
// Self-checking bench for bus_slave_regfile. It drives two builds: index 0 has
// two wait states and index 1 has none. Both are checked against an array model
// of the register file and against the expected strobe-to-rdy_ latency.
module tb_bus_slave_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs_v   [2];
    logic        as_v   [2];
    logic        rw_v   [2];
    logic [29:0] addr_v [2];
    logic [31:0] wd_v   [2];
    logic [31:0] rd_v   [2];
    logic        rdy_v  [2];

    int checks = 0;
    int errors = 0;

    logic [31:0] model [2][8];
    int          wait_of [2] = '{2, 0};

    typedef struct {
        logic        rw;
        logic [29:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        logic        b2b;
    } vec_t;
    vec_t vecs [8];

    bus_slave_regfile #(.DATA_W(32), .ADDR_W(30), .REG_NUM(8), .WAIT_CYCLES(2)) dut_w2 (
        .clk(clk), .reset(reset), .cs_(cs_v[0]), .as_(as_v[0]), .rw(rw_v[0]),
        .addr(addr_v[0]), .wr_data(wd_v[0]), .rd_data(rd_v[0]), .rdy_(rdy_v[0])
    );

    bus_slave_regfile #(.DATA_W(32), .ADDR_W(30), .REG_NUM(8), .WAIT_CYCLES(0)) dut_w0 (
        .clk(clk), .reset(reset), .cs_(cs_v[1]), .as_(as_v[1]), .rw(rw_v[1]),
        .addr(addr_v[1]), .wr_data(wd_v[1]), .rd_data(rd_v[1]), .rdy_(rdy_v[1])
    );

    // Free-running clock with a 10-time-unit period.
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference behaviour: in-range writes update the array, in-range reads return
    // it, and any address with a bit set at or above bit 3 reads as zero.
    task automatic model_access(input int s, input logic r, input logic [29:0] a,
                                input logic [31:0] d, output logic [31:0] exp);
        exp = 32'd0;
        if (a < 30'd8) begin
            if (!r) model[s][a[2:0]] = d;
            if (r) exp = model[s][a[2:0]];
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 8; i++)
                model[s][i] = 32'd0;
    endtask

    // Run one access. Return the data seen while rdy_ is low and the number of
    // cycles from the strobe edge to rdy_ low, or -1 if rdy_ never arrives.
    task automatic access(input int s, input logic r, input logic [29:0] a,
                          input logic [31:0] d, input logic chk_w,
                          output logic [31:0] rdat, output int lat);
        cs_v[s] = 1'b0; as_v[s] = 1'b0; rw_v[s] = r; addr_v[s] = a; wd_v[s] = d;
        @(posedge clk); #1;
        as_v[s] = 1'b1;
        lat = -1;
        rdat = 32'd0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (rdy_v[s] == 1'b0) begin
                lat = k;
                rdat = rd_v[s];
                break;
            end
        end
        cs_v[s] = 1'b1;
        if (chk_w && lat >= 0) begin
            @(posedge clk); #1;
            check("rdy_one_cycle", {31'd0, rdy_v[s]}, 32'd1);
            check("rd_data_idle", rd_v[s], 32'd0);
        end
    endtask

    initial begin
        logic [31:0] rdat;
        logic [31:0] exp;
        int          lat;
        int          pulses;
        int          first;

        vecs[0] = '{rw: 1'b0, addr: 30'd3,     wdata: 32'hDEADBEEF, exp: 32'd0,        b2b: 1'b1};
        vecs[1] = '{rw: 1'b1, addr: 30'd3,     wdata: 32'd0,        exp: 32'hDEADBEEF, b2b: 1'b0};
        vecs[2] = '{rw: 1'b0, addr: 30'h100,   wdata: 32'h1234,     exp: 32'd0,        b2b: 1'b0};
        vecs[3] = '{rw: 1'b1, addr: 30'd0,     wdata: 32'd0,        exp: 32'd0,        b2b: 1'b0};
        vecs[4] = '{rw: 1'b1, addr: 30'h100,   wdata: 32'd0,        exp: 32'd0,        b2b: 1'b0};
        vecs[5] = '{rw: 1'b0, addr: 30'd7,     wdata: 32'hA5A50F0F, exp: 32'd0,        b2b: 1'b1};
        vecs[6] = '{rw: 1'b1, addr: 30'd7,     wdata: 32'd0,        exp: 32'hA5A50F0F, b2b: 1'b0};
        vecs[7] = '{rw: 1'b1, addr: 30'd3,     wdata: 32'd0,        exp: 32'hDEADBEEF, b2b: 1'b0};

        reset = 1'b1;
        for (int s = 0; s < 2; s++) begin
            cs_v[s] = 1'b1; as_v[s] = 1'b1; rw_v[s] = 1'b1; addr_v[s] = 30'd0; wd_v[s] = 32'd0;
        end
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            check("reset_rdy", {31'd0, rdy_v[s]}, 32'd1);
            check("reset_rd_data", rd_v[s], 32'd0);
        end
        reset = 1'b0;

        // After reset every register reads as zero, and the latency is the wait count plus one.
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 8; i++) begin
                access(s, 1'b1, 30'(i), 32'd0, 1'b1, rdat, lat);
                check("reset_read", rdat, 32'd0);
                check("latency_reset_read", 32'(lat), 32'(wait_of[s] + 1));
            end
        end

        // Directed table on both builds.
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 8; i++) begin
                model_access(s, vecs[i].rw, vecs[i].addr, vecs[i].wdata, exp);
                access(s, vecs[i].rw, vecs[i].addr, vecs[i].wdata, !vecs[i].b2b, rdat, lat);
                check("table_latency", 32'(lat), 32'(wait_of[s] + 1));
                if (vecs[i].rw) check("table_rd_data", rdat, vecs[i].exp);
            end
        end

        // Abort: cs_ is raised during WAIT. No rdy_ may appear, and the write is lost.
        cs_v[0] = 1'b0; as_v[0] = 1'b0; rw_v[0] = 1'b0; addr_v[0] = 30'd1; wd_v[0] = 32'h55;
        @(posedge clk); #1;
        as_v[0] = 1'b1;
        @(posedge clk); #1;
        cs_v[0] = 1'b1;
        pulses = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (rdy_v[0] == 1'b0) pulses++;
        end
        check("abort_no_rdy", 32'(pulses), 32'd0);
        access(0, 1'b1, 30'd1, 32'd0, 1'b1, rdat, lat);
        check("abort_no_write", rdat, 32'd0);

        // Reset during WAIT of a write: no rdy_, and every register is cleared.
        cs_v[0] = 1'b0; as_v[0] = 1'b0; rw_v[0] = 1'b0; addr_v[0] = 30'd2; wd_v[0] = 32'hCAFEF00D;
        @(posedge clk); #1;
        as_v[0] = 1'b1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        cs_v[0] = 1'b1;
        model_clear();
        pulses = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (rdy_v[0] == 1'b0) pulses++;
        end
        check("reset_abort_no_rdy", 32'(pulses), 32'd0);
        access(0, 1'b1, 30'd2, 32'd0, 1'b1, rdat, lat);
        check("reset_abort_no_write", rdat, 32'd0);
        access(0, 1'b1, 30'd3, 32'd0, 1'b1, rdat, lat);
        check("reset_clears_regs", rdat, 32'd0);

        // A strobe raised during WAIT is dropped: only one rdy_ pulse, at the normal latency.
        cs_v[0] = 1'b0; as_v[0] = 1'b0; rw_v[0] = 1'b0; addr_v[0] = 30'd4; wd_v[0] = 32'h11112222;
        @(posedge clk); #1;
        as_v[0] = 1'b1;
        @(posedge clk); #1;
        as_v[0] = 1'b0; rw_v[0] = 1'b1; addr_v[0] = 30'd5;
        @(posedge clk); #1;
        as_v[0] = 1'b1;
        pulses = 0;
        first = -1;
        for (int k = 3; k <= 10; k++) begin
            @(posedge clk); #1;
            if (rdy_v[0] == 1'b0) begin
                pulses++;
                if (first < 0) first = k;
            end
        end
        cs_v[0] = 1'b1;
        check("drop_pulse_count", 32'(pulses), 32'd1);
        check("drop_latency", 32'(first), 32'd3);
        model_access(0, 1'b0, 30'd4, 32'h11112222, exp);
        access(0, 1'b1, 30'd4, 32'd0, 1'b1, rdat, lat);
        check("drop_first_write", rdat, 32'h11112222);
        access(0, 1'b1, 30'd5, 32'd0, 1'b1, rdat, lat);
        check("drop_second_ignored", rdat, model[0][5]);

        // Random traffic: in-range and out-of-range addresses, random gaps including back-to-back.
        for (int s = 0; s < 2; s++) begin
            for (int it = 0; it < 150; it++) begin
                logic        r;
                logic [29:0] a;
                logic [31:0] d;
                int          sel;
                int          gap;
                r   = 1'($urandom % 2);
                sel = int'($urandom_range(0, 9));
                if (sel < 8) a = 30'(sel);
                else if (sel == 8) a = 30'd8;
                else a = 30'd1 << $urandom_range(3, 29);
                a = (sel == 9) ? (a | 30'(sel % 8)) : a;
                d   = $urandom;
                gap = int'($urandom_range(0, 2));
                repeat (gap) begin
                    @(posedge clk); #1;
                end
                model_access(s, r, a, d, exp);
                access(s, r, a, d, 1'($urandom % 2), rdat, lat);
                check("rand_latency", 32'(lat), 32'(wait_of[s] + 1));
                if (r) check("rand_rd_data", rdat, exp);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
